// File: rtl/reg_file_gen_pkg.sv
// Shared types and helpers for the reg_file_gen register file.
// Optional write-to-read bypass is enabled by defining REG_FILE_GEN_BYPASS_EN.
package reg_file_gen_pkg;

  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_ADDR_W = 4;

  // Low bit of lane idx in a packed bus of w-bit lanes.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: storage mux, R0 masking and optional
// same-cycle write bypass (REG_FILE_GEN_BYPASS_EN).
module reg_file_rd_port
  import reg_file_gen_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int R0_ZERO = 0,
  localparam int DEPTH  = 2**ADDR_W
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] regs,
  input  logic [ADDR_W-1:0]           rd_addr,
  input  logic                        wr_acc,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  output logic [WIDTH-1:0]            rd_data
);

  logic [WIDTH-1:0] stored;

  assign stored = ((R0_ZERO != 0) && (rd_addr == '0)) ? '0 : regs[rd_addr];

`ifdef REG_FILE_GEN_BYPASS_EN
  // wr_acc already excludes the masked R0 write, so no extra R0 term here.
  assign rd_data = (wr_acc && (rd_addr == wr_addr)) ? wr_data : stored;
`else
  logic unused_byp;
  assign unused_byp = ^{wr_acc, wr_addr, wr_data};
  assign rd_data    = stored;
`endif

endmodule

// File: rtl/reg_file_gen.sv
// Parameterised register file with flush sequencer and N read ports.
// Define REG_FILE_GEN_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file_gen
  import reg_file_gen_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_RD  = 2,
  parameter int NUM_DBG = 4,
  parameter int R0_ZERO = 0
) (
  input  logic                      clk,
  input  logic                      clear,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  output logic                      wr_rej,
  input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD*WIDTH-1:0]   rd_data,
  input  logic                      flush_req,
  output logic                      busy,
  output logic                      flush_done,
  output logic [NUM_DBG*WIDTH-1:0]  dbg_regs
);

  localparam int DEPTH = 2**ADDR_W;

  state_t                      state;
  logic [ADDR_W-1:0]           cnt;
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic                        wr_acc;

  assign wr_acc = wr_en && (state == ST_IDLE) &&
                  !((R0_ZERO != 0) && (wr_addr == '0));

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      mem        <= '0;
      busy       <= 1'b0;
      flush_done <= 1'b0;
      wr_rej     <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      wr_rej     <= wr_en && (state == ST_FLUSH);
      case (state)
        ST_IDLE: begin
          // A write accepted alongside flush_req lands now and is swept later.
          if (wr_acc) mem[wr_addr] <= wr_data;
          if (flush_req) begin
            state <= ST_FLUSH;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_FLUSH: begin
          mem[cnt] <= '0;
          cnt      <= cnt + 1'b1;
          if (&cnt) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            flush_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    reg_file_rd_port #(
      .WIDTH   (WIDTH),
      .ADDR_W  (ADDR_W),
      .R0_ZERO (R0_ZERO)
    ) u_rd (
      .regs    (mem),
      .rd_addr (rd_addr[slice_lo(k, ADDR_W) +: ADDR_W]),
      .wr_acc  (wr_acc),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (rd_data[slice_lo(k, WIDTH) +: WIDTH])
    );
  end

  assign dbg_regs = mem[NUM_DBG-1:0];

endmodule
